fft_frame_ctrl: RTL and testbench

Frame controller between the FIR output stream and the first FFT stage. It collects N consecutive FIR samples into ping-pong frame banks and hands each completed frame to the FFT engine with a start/stream/done handshake. It orders samples naturally or bit-reversed, and flags overruns when the FFT cannot keep pace with the FIR.

---
 rtl/fft_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Collects N FIR samples into ping-pong banks and streams each full bank to
// the FFT with a start/stream/done handshake, in natural or bit-reversed order.
module fft_frame_ctrl #(
    parameter int N      = 16,
    parameter int DW     = 16,
    parameter int BITREV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fir_valid,
    input  logic [DW-1:0]        fir_d,
    input  logic                 fft_ready,
    input  logic                 fft_done,
    input  logic                 ovr_clr,
    output logic                 fft_start,
    output logic                 fft_in_valid,
    output logic [$clog2(N)-1:0] fft_in_idx,
    output logic [DW-1:0]        fft_d_in,
    output logic                 busy,
    output logic                 frame_overrun,
    output logic [7:0]           frame_cnt
);
    localparam int LW = $clog2(N);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, START, STREAM, WAIT_DONE} state_t;

    state_t        state_reg;
    logic [DW-1:0] mem [0:2*N-1];
    logic [DW-1:0] rd_data_reg;
    logic [1:0]    full_reg;
    logic [1:0]    full_next;
    logic          wr_bank_reg;
    logic          rd_bank_reg;
    logic [LW-1:0] wr_idx_reg;
    logic [LW-1:0] k_reg;
    logic [LW-1:0] k_next;
    logic [LW-1:0] k_rev;
    logic [LW-1:0] rd_pos;
    logic          fft_start_reg;
    logic          fft_in_valid_reg;
    logic          overrun_reg;
    logic [7:0]    frame_cnt_reg;
    logic          wr_full;
    logic          wr_en;
    logic          wr_last;
    logic          release_now;
    logic          rd_en;

    // full is judged on the registered flag, so a write into a bank being
    // released in the same cycle is still dropped
    assign wr_full     = full_reg[wr_bank_reg];
    assign wr_en       = fir_valid && !wr_full;
    assign wr_last     = wr_en && (wr_idx_reg == LW'(N - 1));
    assign release_now = (state_reg == WAIT_DONE) && fft_done;

    // Read address runs one cycle ahead of the registered stream outputs
    assign k_next = (state_reg == START) ? '0 : k_reg + LW'(1);
    assign rd_en  = (state_reg == START) || ((state_reg == STREAM) && (k_reg != LW'(N - 1)));
    assign rd_pos = (BITREV != 0) ? k_rev : k_next;

    for (genvar gi = 0; gi < LW; gi++) begin : g_rev
        assign k_rev[gi] = k_next[LW-1-gi];
    end

    // Completing one bank and releasing the other can coincide; they never hit the same bank
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
        assign full_next[gi] = (full_reg[gi] && !(release_now && (rd_bank_reg == 1'(gi))))
                             || (wr_last && (wr_bank_reg == 1'(gi)));
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_idx_reg}] <= fir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[{rd_bank_reg, rd_pos}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            full_reg         <= '0;
            wr_bank_reg      <= 1'b0;
            rd_bank_reg      <= 1'b0;
            wr_idx_reg       <= '0;
            k_reg            <= '0;
            fft_start_reg    <= 1'b0;
            fft_in_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            full_reg <= full_next;

            if (wr_en) begin
                if (wr_last) begin
                    wr_idx_reg  <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else begin
                    wr_idx_reg <= wr_idx_reg + LW'(1);
                end
            end

            if (fir_valid && wr_full) begin
                overrun_reg <= 1'b1;
            end else if (ovr_clr) begin
                overrun_reg <= 1'b0;
            end

            fft_start_reg    <= 1'b0;
            fft_in_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (full_reg[rd_bank_reg]) begin
                        state_reg <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (fft_ready) begin
                        state_reg     <= START;
                        fft_start_reg <= 1'b1;
                    end
                end
                START: begin
                    state_reg        <= STREAM;
                    fft_in_valid_reg <= 1'b1;
                    k_reg            <= k_next;
                end
                STREAM: begin
                    if (k_reg == LW'(N - 1)) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        fft_in_valid_reg <= 1'b1;
                        k_reg            <= k_next;
                    end
                end
                WAIT_DONE: begin
                    if (fft_done) begin
                        rd_bank_reg   <= ~rd_bank_reg;
                        frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fft_start     = fft_start_reg;
    assign fft_in_valid  = fft_in_valid_reg;
    assign fft_in_idx    = k_reg;
    assign fft_d_in      = rd_data_reg;
    assign busy          = (state_reg != IDLE);
    assign frame_overrun = overrun_reg;
    assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Drives a natural-order and a bit-reversed instance in lockstep and scores
// every streamed sample against frames queued when the samples were sent.
module tb_fft_frame_ctrl;
    localparam int N  = 16;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          fir_valid;
    logic [DW-1:0] fir_d;
    logic          fft_ready;
    logic          fft_done;
    logic          ovr_clr;

    logic          start0, v0, busy0, ovr0;
    logic [3:0]    idx0;
    logic [DW-1:0] d0;
    logic [7:0]    fc0;
    logic          start1, v1, busy1, ovr1;
    logic [3:0]    idx1;
    logic [DW-1:0] d1;
    logic [7:0]    fc1;

    fft_frame_ctrl #(.N(N), .DW(DW), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .fft_ready(fft_ready), .fft_done(fft_done), .ovr_clr(ovr_clr),
        .fft_start(start0), .fft_in_valid(v0), .fft_in_idx(idx0), .fft_d_in(d0),
        .busy(busy0), .frame_overrun(ovr0), .frame_cnt(fc0)
    );

    fft_frame_ctrl #(.N(N), .DW(DW), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .fft_ready(fft_ready), .fft_done(fft_done), .ovr_clr(ovr_clr),
        .fft_start(start1), .fft_in_valid(v1), .fft_in_idx(idx1), .fft_d_in(d1),
        .busy(busy1), .frame_overrun(ovr1), .frame_cnt(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int brev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [DW-1:0] frame_q [$];
    int  pos;
    int  vectors;
    int  miscompares;
    int  start_cnt;
    int  done_cnt;
    int  done_delay;
    bit  auto_done;
    bit  prev_start;
    bit  prev_valid;
    int  prev_idx;
    int  exp_cnt;

    task automatic monitor();
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        if (prev_valid && prev_idx != N - 1) begin
            vectors++;
            if (v0 !== 1'b1 || v1 !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_gap after idx=%0d: valid0=%b valid1=%b required 1", prev_idx, v0, v1);
            end
        end
        if (prev_start) begin
            vectors++;
            if (v0 !== 1'b1 || v1 !== 1'b1 || idx0 !== 4'd0) begin
                miscompares++;
                $display("FAIL start_to_valid: valid0=%b valid1=%b idx0=%0d required 1,1,0", v0, v1, idx0);
            end
        end
        if (v0 === 1'b1 || v1 === 1'b1) begin
            vectors++;
            if (frame_q.size() < N) begin
                miscompares++;
                $display("FAIL unexpected_stream: idx0=%0d d0=%h with %0d samples queued", idx0, d0, frame_q.size());
            end else begin
                e0 = frame_q[pos];
                e1 = frame_q[brev_tab[pos]];
                if (v0 !== 1'b1 || v1 !== 1'b1 || idx0 !== 4'(pos) || idx1 !== 4'(pos)
                    || d0 !== e0 || d1 !== e1) begin
                    miscompares++;
                    $display("FAIL stream_sample k=%0d: got idx0=%0d d0=%h idx1=%0d d1=%h, required idx=%0d d0=%h d1=%h",
                             pos, idx0, d0, idx1, d1, pos, e0, e1);
                end
                if (pos == N - 1) begin
                    for (int i = 0; i < N; i++) void'(frame_q.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (v0 === 1'b1 && idx0 == 4'(N - 1) && auto_done) done_cnt = done_delay;
        end
        if (start0 === 1'b1) start_cnt++;
        prev_start = (start0 === 1'b1);
        prev_valid = (v0 === 1'b1);
        prev_idx   = int'(idx0);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) fft_done = 1'b1;
        end
    endtask

    task automatic send(input logic [DW-1:0] value, input bit keep);
        fir_valid = 1'b1;
        fir_d     = value;
        if (keep) frame_q.push_back(value);
        step();
        fir_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int i;
        for (i = 0; i < 400; i++) begin
            if (fc0 == 8'(target)) break;
            step();
        end
        if (i == 400) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: frame_cnt=%0d required %0d", fc0, target);
        end
    endtask

    task automatic check_status(input string name, input logic [7:0] cnt, input logic ovr, input logic bsy);
        vectors++;
        if (fc0 !== cnt || fc1 !== cnt || ovr0 !== ovr || ovr1 !== ovr || busy0 !== bsy || busy1 !== bsy) begin
            miscompares++;
            $display("FAIL %s: cnt=%0d/%0d ovr=%b/%b busy=%b/%b required cnt=%0d ovr=%b busy=%b",
                     name, fc0, fc1, ovr0, ovr1, busy0, busy1, cnt, ovr, bsy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if ({start0, v0, idx0, d0, busy0, ovr0, fc0} !== '0 || {start1, v1, idx1, d1, busy1, ovr1, fc1} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: dut0 %b/%b/%h/%h/%b/%b/%h dut1 %b/%b/%h/%h/%b/%b/%h required all 0",
                     start0, v0, idx0, d0, busy0, ovr0, fc0, start1, v1, idx1, d1, busy1, ovr1, fc1);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        start_cnt = 0;
        fft_ready = 1'b1;
        for (int i = 0; i < N; i++) send(16'((32'd1 << i) - 32'd1), 1'b1);
        wait_frames(1);
        exp_cnt = 1;
        check_status("single_frame_status", 8'(exp_cnt), 1'b0, 1'b0);
        vectors++;
        if (start_cnt != 1 || frame_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_frame_starts: starts=%0d left=%0d required 1 and 0", start_cnt, frame_q.size());
        end
    endtask

    task automatic test_bitrev();
        for (int i = 0; i < N; i++) send(16'(i), 1'b1);
        wait_frames(exp_cnt + 1);
        exp_cnt++;
        check_status("bitrev_status", 8'(exp_cnt), 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        done_delay = 3;
        for (int i = 0; i < 2 * N; i++) send(16'($urandom), 1'b1);
        wait_frames(exp_cnt + 2);
        exp_cnt += 2;
        check_status("ping_pong_status", 8'(exp_cnt), 1'b0, 1'b0);
        done_delay = 1;
    endtask

    task automatic test_overrun();
        fft_ready = 1'b0;
        for (int i = 0; i < 40; i++) send(16'(i), i < 2 * N);
        check_status("overrun_set", 8'(exp_cnt), 1'b1, 1'b1);
        fft_ready = 1'b1;
        wait_frames(exp_cnt + 2);
        exp_cnt += 2;
        check_status("overrun_sticky", 8'(exp_cnt), 1'b1, 1'b0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check_status("overrun_clear", 8'(exp_cnt), 1'b0, 1'b0);
        // refill both banks, then a dropped sample coinciding with a clear
        fft_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(16'h4000 + 16'(i), 1'b1);
        ovr_clr = 1'b1;
        send(16'hDEAD, 1'b0);
        ovr_clr = 1'b0;
        check_status("set_beats_clear", 8'(exp_cnt), 1'b1, 1'b1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check_status("overrun_clear2", 8'(exp_cnt), 1'b0, 1'b1);
        fft_ready = 1'b1;
        wait_frames(exp_cnt + 2);
        exp_cnt += 2;
        check_status("overrun_drain", 8'(exp_cnt), 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        start_cnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            if (i % 2 == 0) send(16'($urandom), 1'b1);
            else step();
        end
        wait_frames(exp_cnt + 1);
        exp_cnt++;
        check_status("gapped_status", 8'(exp_cnt), 1'b0, 1'b0);
        vectors++;
        if (start_cnt != 1) begin
            miscompares++;
            $display("FAIL gapped_starts: starts=%0d required 1", start_cnt);
        end
    endtask

    task automatic test_reset_mid_stream();
        int i;
        for (int j = 0; j < N; j++) send(16'($urandom), 1'b1);
        for (i = 0; i < 100; i++) begin
            if (v0 === 1'b1 && idx0 == 4'd7) break;
            step();
        end
        vectors++;
        if (i == 100) begin
            miscompares++;
            $display("FAIL reach_k7: idx0=%0d valid0=%b required idx 7 valid 1", idx0, v0);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({start0, v0, idx0, d0, busy0, ovr0, fc0} !== '0 || {start1, v1, idx1, d1, busy1, ovr1, fc1} !== '0) begin
            miscompares++;
            $display("FAIL mid_stream_reset: dut0 %b/%b/%h/%h/%b/%b/%h dut1 %b/%b/%h/%h/%b/%b/%h required all 0",
                     start0, v0, idx0, d0, busy0, ovr0, fc0, start1, v1, idx1, d1, busy1, ovr1, fc1);
        end
        frame_q.delete();
        pos        = 0;
        done_cnt   = 0;
        prev_valid = 1'b0;
        prev_start = 1'b0;
        start_cnt  = 0;
        rst = 1'b0;
        step();
        for (int j = 0; j < N; j++) send(16'h1000 + 16'(j * 3), 1'b1);
        wait_frames(1);
        check_status("after_reset_frame", 8'd1, 1'b0, 1'b0);
        vectors++;
        if (start_cnt != 1 || frame_q.size() != 0) begin
            miscompares++;
            $display("FAIL after_reset_starts: starts=%0d left=%0d required 1 and 0", start_cnt, frame_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; fir_valid = 1'b0; fir_d = '0; fft_ready = 1'b0;
        fft_done = 1'b0; ovr_clr = 1'b0;
        pos = 0; vectors = 0; miscompares = 0; start_cnt = 0;
        done_cnt = 0; done_delay = 1; auto_done = 1'b1;
        prev_start = 1'b0; prev_valid = 1'b0; prev_idx = 0; exp_cnt = 0;

        test_reset();
        test_single_frame();
        test_bitrev();
        test_back_to_back();
        test_overrun();
        test_gapped();
        test_reset_mid_stream();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
